// File: rtl/timer_arbiter.sv
// rtl/timer_arbiter.sv - round-robin arbiter sequencing one shared down-counter timer
//
// Grants the shared timer to one requester at a time, loads that requester's
// interval, counts it down to zero, pulses the requester's done line and
// releases the timer. Arbitration is round-robin starting after the last
// grantee; req[0] has first priority after reset.
//
// Optional build macro:
//   TIMER_ARB_ABORT_EN - the grantee dropping req during LOAD or RUN aborts
//                        the interval (back to IDLE, count cleared, no done).
//
// Ports:
//   clk       rising-edge clock
//   reset_n   asynchronous active-low reset
//   req       level request, one bit per requester
//   load_val  interval per requester, slice i = [i*CNT_WIDTH +: CNT_WIDTH]
//   gnt       registered one-hot grant
//   gnt_id    index of current / last grantee
//   busy      high whenever the sequencer is not idle
//   count     current timer value
//   done      one-cycle pulse to the grantee when its interval expires
module timer_arbiter #(
  parameter int CNT_WIDTH = 8,
  parameter int NUM_REQ   = 4,
  localparam int ID_W     = $clog2(NUM_REQ)
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ*CNT_WIDTH-1:0]   load_val,
  output logic [NUM_REQ-1:0]             gnt,
  output logic [ID_W-1:0]                gnt_id,
  output logic                           busy,
  output logic [CNT_WIDTH-1:0]           count,
  output logic [NUM_REQ-1:0]             done
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  state_t                 state, state_nxt;
  logic [ID_W-1:0]        last_id, last_id_nxt;
  logic [ID_W-1:0]        gnt_id_nxt;
  logic [NUM_REQ-1:0]     gnt_nxt, done_nxt;
  logic [CNT_WIDTH-1:0]   count_nxt;
  logic [ID_W-1:0]        win_id;
  logic                   win_found;
  logic                   abort;
  int                     rr_idx;

  // Round-robin search: first requester at or after last_id+1, wrapping.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    rr_idx    = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      rr_idx = (int'(last_id) + k) % NUM_REQ;
      if (!win_found && req[rr_idx]) begin
        win_found = 1'b1;
        win_id    = ID_W'(rr_idx);
      end
    end
  end

`ifdef TIMER_ARB_ABORT_EN
  assign abort = !req[gnt_id];
`else
  assign abort = 1'b0;
`endif

  always_comb begin
    state_nxt   = state;
    gnt_nxt     = gnt;
    gnt_id_nxt  = gnt_id;
    last_id_nxt = last_id;
    count_nxt   = count;
    done_nxt    = '0;
    case (state)
      IDLE: begin
        if (win_found) begin
          state_nxt   = LOAD;
          gnt_nxt     = NUM_REQ'(1) << win_id;
          gnt_id_nxt  = win_id;
          last_id_nxt = win_id;
        end
      end
      LOAD: begin
        if (abort) begin
          state_nxt = IDLE;
          count_nxt = '0;
          gnt_nxt   = '0;
        end else begin
          // Interval is captured only here; later load_val changes are ignored.
          count_nxt = load_val[int'(gnt_id)*CNT_WIDTH +: CNT_WIDTH];
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (abort) begin
          state_nxt = IDLE;
          count_nxt = '0;
          gnt_nxt   = '0;
        end else if (count == '0) begin
          state_nxt = DONE;
          done_nxt  = gnt;
        end else begin
          count_nxt = count - CNT_WIDTH'(1);
        end
      end
      DONE: begin
        state_nxt = IDLE;
        gnt_nxt   = '0;
      end
      default: begin
        state_nxt = IDLE;
        gnt_nxt   = '0;
        count_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      gnt     <= '0;
      gnt_id  <= '0;
      last_id <= ID_W'(NUM_REQ - 1);
      count   <= '0;
      done    <= '0;
    end else begin
      state   <= state_nxt;
      gnt     <= gnt_nxt;
      gnt_id  <= gnt_id_nxt;
      last_id <= last_id_nxt;
      count   <= count_nxt;
      done    <= done_nxt;
    end
  end

  assign busy = (state != IDLE);

endmodule
